arch_map_table_param: RTL and testbench
=======================================

Name: arch_map_table_param

Overview:
Parametrised architectural map table (AMT). It holds the committed logical-to-physical register mapping and is written by up to COMMIT_WIDTH retiring instructions per cycle. For each retiring instruction it releases the superseded physical register to the free list. On recovery, a walk FSM streams the whole table to the rename map table, RECOVER_WIDTH entries per cycle, with a start/done handshake. Sits between the active list (commit side) and the RMT/free list.

Parameters:
COMMIT_WIDTH, 4, number of commit lanes; lane 0 is the oldest.
NUM_LOG, 34, number of logical registers (AMT entries); need not be a multiple of RECOVER_WIDTH.
LOG_W, 6, logical index width; must satisfy 2^LOG_W >= NUM_LOG.
PHY_W, 7, physical tag width; must satisfy 2^PHY_W >= NUM_LOG.
RECOVER_WIDTH, 4, entries emitted per recovery cycle (RMT write ports).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
commit_valid_i  in  COMMIT_WIDTH  per-lane commit with a destination register
commit_log_i  in  COMMIT_WIDTH*LOG_W  per-lane logical destination (lane k at [k*LOG_W +: LOG_W])
commit_phy_i  in  COMMIT_WIDTH*PHY_W  per-lane new physical destination
commit_ready_o  out  1  high when commits are accepted (FSM in IDLE)
release_valid_o  out  COMMIT_WIDTH  per-lane release valid
release_phy_o  out  COMMIT_WIDTH*PHY_W  per-lane released physical tag
recover_req_i  in  1  one-cycle pulse that starts a recovery walk
recover_busy_o  out  1  high while the walk runs
recover_valid_o  out  RECOVER_WIDTH  per-lane valid of the recovery packet
recover_log_o  out  RECOVER_WIDTH*LOG_W  logical index per recovery lane
recover_phy_o  out  RECOVER_WIDTH*PHY_W  committed mapping per recovery lane
recover_done_o  out  1  one-cycle pulse after the last group
parity_err_o  out  1  sticky parity error (tied 0 without AMT_PARITY_EN)

Behaviour:
- Reset: entry i = i for every i < NUM_LOG (identity map). FSM goes to IDLE, walk counter = 0.
- Reset values of outputs: commit_ready_o = 1; all valid, busy, done and err outputs = 0; data outputs = 0.
- Commit, IDLE only:
  - Lane k writes the table unless some younger lane j > k is valid with the same logical destination. Only the youngest lane for a given destination writes.
  - Writes take effect at the clock edge; reads are combinational from pre-edge state.
- Release, same cycle as commit, combinational:
  - release_valid_o[k] = commit_valid_i[k] & commit_ready_o.
  - If lane k is superseded by a younger lane, release_phy[k] = commit_phy[k].
  - Otherwise, release_phy[k] = table[commit_log[k]] (pre-edge value).
  - Released tags are exactly the dead mappings; no tag is released twice.
- Commits while commit_ready_o = 0 are ignored: no write, no release. The active list must hold them.
- Walk FSM states: IDLE -> WALK -> DONE -> IDLE.
  - IDLE: recover_req_i = 1 moves to WALK. The table snapshot includes commits accepted in the same cycle, because the walk starts next cycle.
  - WALK: each cycle emit group g. Lane r carries index g*RECOVER_WIDTH + r, valid iff index < NUM_LOG; invalid lanes drive data 0. The counter advances by RECOVER_WIDTH. After the group containing NUM_LOG-1, go to DONE.
  - Walk length: ceil(NUM_LOG/RECOVER_WIDTH) cycles. Default: 9 cycles; the last group has lanes 0-1 valid.
  - DONE: recover_done_o = 1 for one cycle, counter returns to 0, then IDLE. commit_ready_o goes high the cycle after DONE.
  - recover_busy_o = 1 in WALK and DONE; commit_ready_o = 0 in WALK and DONE.
- recover_req_i during WALK or DONE is ignored; it does not restart the walk.
- Reset mid-walk: immediate IDLE, identity table, no done pulse.
- Index arithmetic is done at LOG_W+1 bits so the last-group comparison cannot wrap.

Optional Feature:
AMT_PARITY_EN
- Defined:
  - Each entry stores an even-parity bit, written with the data and set correctly at reset.
  - Every entry read for a release or recovery lane that is valid is checked.
  - Any mismatch sets parity_err_o at the next edge; it stays set until reset.
  - Data paths are unaffected.
- Undefined: no parity storage; parity_err_o is tied 0.

Test Plan:
- Reset, then commit lane0 log=5 phy=40 -> release_phy[0]=5, valid; the next walk shows entry 5 = 40.
- Same cycle: lane0 log=3 phy=50, lane2 log=3 phy=51, lane3 log=3 phy=52 -> releases lane0=50, lane2=51, lane3=3; table[3]=52. An invalid lane1 with log=3 changes nothing.
- recover_req_i pulse with default parameters:
  - busy for 10 cycles, i.e. 9 WALK + 1 DONE.
  - The group 8 packet has recover_valid_o=4'b0011 with indices 32 and 33.
  - done pulses on cycle 10; commit_ready_o rises on cycle 11.
- Commit during WALK (log=7 phy=60) -> no release; table[7] unchanged in the next walk. A second recover_req_i mid-walk does not extend the walk.
- Reset asserted at walk cycle 4 -> busy=0 the next cycle, no done pulse, the next walk returns the identity map.
- With AMT_PARITY_EN: force a parity bit flip on entry 9, then commit log=9 -> parity_err_o=1 the next cycle and stays 1 until reset.

Source files
------------

// File: rtl/arch_map_table_param.sv
// Architectural map table: committed logical-to-physical map with per-lane release and a recovery walk.
// Optional parity protection of the entries is enabled with `define AMT_PARITY_EN.
module arch_map_table_param #(
    parameter int COMMIT_WIDTH  = 4,
    parameter int NUM_LOG       = 34,
    parameter int LOG_W         = 6,
    parameter int PHY_W         = 7,
    parameter int RECOVER_WIDTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [COMMIT_WIDTH-1:0]          commit_valid_i,
    input  logic [COMMIT_WIDTH*LOG_W-1:0]    commit_log_i,
    input  logic [COMMIT_WIDTH*PHY_W-1:0]    commit_phy_i,
    output logic                             commit_ready_o,
    output logic [COMMIT_WIDTH-1:0]          release_valid_o,
    output logic [COMMIT_WIDTH*PHY_W-1:0]    release_phy_o,
    input  logic                             recover_req_i,
    output logic                             recover_busy_o,
    output logic [RECOVER_WIDTH-1:0]         recover_valid_o,
    output logic [RECOVER_WIDTH*LOG_W-1:0]   recover_log_o,
    output logic [RECOVER_WIDTH*PHY_W-1:0]   recover_phy_o,
    output logic                             recover_done_o,
    output logic                             parity_err_o
);
    localparam int CNT_W = LOG_W + 1;

    // Handshake: a commit lane is consumed when commit_valid_i[k] and commit_ready_o are
    // both high at the edge; release_valid_o mirrors that acceptance in the same cycle.
    typedef enum logic [1:0] {ST_IDLE, ST_WALK, ST_DONE} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [PHY_W-1:0]          map_q [NUM_LOG];
    logic [COMMIT_WIDTH-1:0]   accept, superseded, write_en;
    logic [CNT_W-1:0]          walk_idx [RECOVER_WIDTH];

    assign commit_ready_o = (state_q == ST_IDLE);
    assign recover_busy_o = (state_q != ST_IDLE);
    assign recover_done_o = (state_q == ST_DONE);
    assign accept         = commit_valid_i & {COMMIT_WIDTH{commit_ready_o}};
    assign write_en       = accept & ~superseded;

    // A lane is dead on arrival when a younger valid lane names the same destination.
    always_comb begin
        superseded = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            for (int j = k + 1; j < COMMIT_WIDTH; j++) begin
                if (commit_valid_i[j] &&
                    commit_log_i[j*LOG_W +: LOG_W] == commit_log_i[k*LOG_W +: LOG_W])
                    superseded[k] = 1'b1;
            end
        end
    end

    always_comb begin
        release_valid_o = accept;
        release_phy_o   = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (accept[k])
                release_phy_o[k*PHY_W +: PHY_W] = superseded[k] ? commit_phy_i[k*PHY_W +: PHY_W]
                                                                : map_q[commit_log_i[k*LOG_W +: LOG_W]];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (recover_req_i) state_d = ST_WALK;
            ST_WALK: begin
                cnt_d = cnt_q + CNT_W'(RECOVER_WIDTH);
                if (cnt_q + CNT_W'(RECOVER_WIDTH) >= CNT_W'(NUM_LOG)) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        for (int r = 0; r < RECOVER_WIDTH; r++) walk_idx[r] = cnt_q + CNT_W'(r);
    end

    always_comb begin
        recover_valid_o = '0;
        recover_log_o   = '0;
        recover_phy_o   = '0;
        if (state_q == ST_WALK) begin
            for (int r = 0; r < RECOVER_WIDTH; r++) begin
                if (walk_idx[r] < CNT_W'(NUM_LOG)) begin
                    recover_valid_o[r]               = 1'b1;
                    recover_log_o[r*LOG_W +: LOG_W]  = walk_idx[r][LOG_W-1:0];
                    recover_phy_o[r*PHY_W +: PHY_W]  = map_q[walk_idx[r][LOG_W-1:0]];
                end
            end
        end
    end

`ifdef AMT_PARITY_EN
    logic par_q [NUM_LOG];
    logic par_err_d, parity_err_q;

    always_comb begin
        par_err_d = 1'b0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (write_en[k] &&
                ^{map_q[commit_log_i[k*LOG_W +: LOG_W]], par_q[commit_log_i[k*LOG_W +: LOG_W]]})
                par_err_d = 1'b1;
        end
        for (int r = 0; r < RECOVER_WIDTH; r++) begin
            if (recover_valid_o[r] &&
                ^{map_q[walk_idx[r][LOG_W-1:0]], par_q[walk_idx[r][LOG_W-1:0]]})
                par_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)          parity_err_q <= 1'b0;
        else if (par_err_d) parity_err_q <= 1'b1;
    end

    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LOG; i++) begin
                map_q[i] <= PHY_W'(i);
`ifdef AMT_PARITY_EN
                par_q[i] <= ^(PHY_W'(i));
`endif
            end
        end else begin
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (write_en[k]) begin
                    map_q[commit_log_i[k*LOG_W +: LOG_W]] <= commit_phy_i[k*PHY_W +: PHY_W];
`ifdef AMT_PARITY_EN
                    par_q[commit_log_i[k*LOG_W +: LOG_W]] <= ^commit_phy_i[k*PHY_W +: PHY_W];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_arch_map_table_param.sv
// Bench for arch_map_table_param: directed and random commits/walks against an array model of the map.
module tb_arch_map_table_param;
    localparam int CW = 4;
    localparam int NL = 34;
    localparam int LW = 6;
    localparam int PW = 7;
    localparam int RW = 4;
    localparam int GROUPS = (NL + RW - 1) / RW;

    logic              clk = 1'b0;
    logic              reset;
    logic [CW-1:0]     commit_valid_i;
    logic [CW*LW-1:0]  commit_log_i;
    logic [CW*PW-1:0]  commit_phy_i;
    logic              commit_ready_o;
    logic [CW-1:0]     release_valid_o;
    logic [CW*PW-1:0]  release_phy_o;
    logic              recover_req_i;
    logic              recover_busy_o;
    logic [RW-1:0]     recover_valid_o;
    logic [RW*LW-1:0]  recover_log_o;
    logic [RW*PW-1:0]  recover_phy_o;
    logic              recover_done_o;
    logic              parity_err_o;

    int model [NL];
    int lane_log [CW];
    int lane_phy [CW];
    int checks = 0;
    int fails  = 0;

    arch_map_table_param dut (
        .clk(clk), .reset(reset),
        .commit_valid_i(commit_valid_i), .commit_log_i(commit_log_i), .commit_phy_i(commit_phy_i),
        .commit_ready_o(commit_ready_o),
        .release_valid_o(release_valid_o), .release_phy_o(release_phy_o),
        .recover_req_i(recover_req_i), .recover_busy_o(recover_busy_o),
        .recover_valid_o(recover_valid_o), .recover_log_o(recover_log_o),
        .recover_phy_o(recover_phy_o), .recover_done_o(recover_done_o),
        .parity_err_o(parity_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset          = 1'b1;
        commit_valid_i = '0;
        commit_log_i   = '0;
        commit_phy_i   = '0;
        recover_req_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < NL; i++) model[i] = i;
    endtask

    // One IDLE cycle of commits (optionally with a recovery request); checks releases, updates the model.
    task automatic commit_cycle(input logic [CW-1:0] v, input bit req);
        logic [CW*PW-1:0] exp_rp;
        bit sup;
        @(negedge clk);
        commit_valid_i = v;
        recover_req_i  = req;
        for (int k = 0; k < CW; k++) begin
            commit_log_i[k*LW +: LW] = LW'(lane_log[k]);
            commit_phy_i[k*PW +: PW] = PW'(lane_phy[k]);
        end
        #1;
        exp_rp = '0;
        for (int k = 0; k < CW; k++) begin
            if (v[k]) begin
                sup = 1'b0;
                for (int j = k + 1; j < CW; j++)
                    if (v[j] && lane_log[j] == lane_log[k]) sup = 1'b1;
                exp_rp[k*PW +: PW] = sup ? PW'(lane_phy[k]) : PW'(model[lane_log[k]]);
            end
        end
        checks++;
        if (commit_ready_o !== 1'b1) begin
            fails++; $display("FAIL commit_ready: got %b want 1", commit_ready_o);
        end
        checks++;
        if (release_valid_o !== v) begin
            fails++; $display("FAIL release_valid: got %b want %b", release_valid_o, v);
        end
        checks++;
        if (release_phy_o !== exp_rp) begin
            fails++; $display("FAIL release_phy: got %h want %h", release_phy_o, exp_rp);
        end
        @(posedge clk);
        for (int k = 0; k < CW; k++)
            if (v[k]) model[lane_log[k]] = lane_phy[k];
        #1;
        commit_valid_i = '0;
        recover_req_i  = 1'b0;
    endtask

    // Follows a walk started by the preceding commit_cycle; optionally injects an ignored commit + request.
    task automatic walk_check(input int inject_at);
        logic [RW-1:0]    ev;
        logic [RW*LW-1:0] el;
        logic [RW*PW-1:0] ep;
        int idx;
        for (int c = 1; c <= GROUPS + 2; c++) begin
            @(negedge clk);
            if (c == inject_at) begin
                commit_valid_i = 4'b0001;
                commit_log_i   = '0;
                commit_phy_i   = '0;
                commit_log_i[LW-1:0] = LW'(7);
                commit_phy_i[PW-1:0] = PW'(60);
                recover_req_i  = 1'b1;
            end
            #1;
            ev = '0; el = '0; ep = '0;
            if (c <= GROUPS) begin
                for (int r = 0; r < RW; r++) begin
                    idx = (c - 1) * RW + r;
                    if (idx < NL) begin
                        ev[r] = 1'b1;
                        el[r*LW +: LW] = LW'(idx);
                        ep[r*PW +: PW] = PW'(model[idx]);
                    end
                end
            end
            checks++;
            if (recover_busy_o !== (c <= GROUPS + 1)) begin
                fails++; $display("FAIL walk_busy c=%0d: got %b want %b", c, recover_busy_o, c <= GROUPS + 1);
            end
            checks++;
            if (recover_done_o !== (c == GROUPS + 1)) begin
                fails++; $display("FAIL walk_done c=%0d: got %b want %b", c, recover_done_o, c == GROUPS + 1);
            end
            checks++;
            if (commit_ready_o !== (c == GROUPS + 2)) begin
                fails++; $display("FAIL walk_ready c=%0d: got %b want %b", c, commit_ready_o, c == GROUPS + 2);
            end
            checks++;
            if (recover_valid_o !== ev || recover_log_o !== el || recover_phy_o !== ep) begin
                fails++;
                $display("FAIL walk_packet c=%0d: got v=%b l=%h p=%h want v=%b l=%h p=%h",
                         c, recover_valid_o, recover_log_o, recover_phy_o, ev, el, ep);
            end
            if (c == GROUPS) begin
                checks++;
                if (recover_valid_o !== 4'b0011) begin
                    fails++; $display("FAIL last_group_valid: got %b want 0011", recover_valid_o);
                end
            end
            if (c == inject_at) begin
                checks++;
                if (release_valid_o !== 4'b0000) begin
                    fails++; $display("FAIL walk_release: got %b want 0000", release_valid_o);
                end
            end
            @(posedge clk);
            #1;
            commit_valid_i = '0;
            recover_req_i  = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (commit_ready_o !== 1'b1 || recover_busy_o !== 1'b0 || recover_done_o !== 1'b0 ||
            parity_err_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got ready=%b busy=%b done=%b err=%b want 1 0 0 0",
                     commit_ready_o, recover_busy_o, recover_done_o, parity_err_o);
        end
        checks++;
        if (release_valid_o !== '0 || release_phy_o !== '0 || recover_valid_o !== '0 ||
            recover_log_o !== '0 || recover_phy_o !== '0) begin
            fails++; $display("FAIL reset_data: outputs not zero rv=%b rp=%h wv=%b",
                              release_valid_o, release_phy_o, recover_valid_o);
        end
        commit_cycle(4'b0000, 1'b1);
        walk_check(0);
    endtask

    task automatic test_directed_commit();
        for (int k = 0; k < CW; k++) begin lane_log[k] = 0; lane_phy[k] = 0; end
        lane_log[0] = 5; lane_phy[0] = 40;
        commit_cycle(4'b0001, 1'b0);
        checks++;
        if (release_phy_o !== '0 && release_valid_o === '0) begin
            fails++; $display("FAIL idle_release_phy: got %h want 0", release_phy_o);
        end
        lane_log[0] = 3; lane_phy[0] = 50;
        lane_log[1] = 3; lane_phy[1] = 99;
        lane_log[2] = 3; lane_phy[2] = 51;
        lane_log[3] = 3; lane_phy[3] = 52;
        commit_cycle(4'b1101, 1'b1);
        walk_check(0);
        checks++;
        if (model[3] !== 52 || model[5] !== 40) begin
            fails++; $display("FAIL directed_model: got t3=%0d t5=%0d want 52 40", model[3], model[5]);
        end
    endtask

    task automatic test_walk_interference();
        commit_cycle(4'b0000, 1'b1);
        walk_check(3);
        commit_cycle(4'b0000, 1'b1);
        walk_check(0);
    endtask

    task automatic test_reset_mid_walk();
        commit_cycle(4'b0000, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); #1;
            checks++;
            if (recover_busy_o !== 1'b1) begin
                fails++; $display("FAIL midwalk_busy c=%0d: got %b want 1", c, recover_busy_o);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (recover_busy_o !== 1'b0 || recover_done_o !== 1'b0 || commit_ready_o !== 1'b1) begin
            fails++; $display("FAIL midwalk_reset: got busy=%b done=%b ready=%b want 0 0 1",
                              recover_busy_o, recover_done_o, commit_ready_o);
        end
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < NL; i++) model[i] = i;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            checks++;
            if (recover_done_o !== 1'b0 || recover_busy_o !== 1'b0) begin
                fails++; $display("FAIL post_reset_idle: got done=%b busy=%b want 0 0",
                                  recover_done_o, recover_busy_o);
            end
        end
        commit_cycle(4'b0000, 1'b1);
        walk_check(0);
    endtask

    task automatic test_random();
        logic [CW-1:0] v;
        for (int n = 0; n < 160; n++) begin
            v = CW'($urandom_range(0, (1 << CW) - 1));
            for (int k = 0; k < CW; k++) begin
                lane_log[k] = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, NL - 1);
                lane_phy[k] = $urandom_range(0, (1 << PW) - 1);
            end
            if (n % 40 == 39) begin
                commit_cycle(v, 1'b1);
                walk_check((n % 80 == 39) ? 5 : 0);
            end else begin
                commit_cycle(v, 1'b0);
            end
        end
        checks++;
        if (parity_err_o !== 1'b0) begin
            fails++; $display("FAIL random_parity: got %b want 0", parity_err_o);
        end
    endtask

`ifdef AMT_PARITY_EN
    task automatic test_parity();
        do_reset();
        @(negedge clk);
        dut.par_q[9] <= ~dut.par_q[9];
        for (int k = 0; k < CW; k++) begin lane_log[k] = 0; lane_phy[k] = 0; end
        lane_log[0] = 9; lane_phy[0] = 70;
        commit_cycle(4'b0001, 1'b0);
        checks++;
        if (parity_err_o !== 1'b1) begin
            fails++; $display("FAIL parity_set: got %b want 1", parity_err_o);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (parity_err_o !== 1'b1) begin
            fails++; $display("FAIL parity_sticky: got %b want 1", parity_err_o);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (parity_err_o !== 1'b0) begin
            fails++; $display("FAIL parity_clear: got %b want 0", parity_err_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed_commit();
        test_walk_interference();
        test_reset_mid_walk();
        test_random();
`ifdef AMT_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
